// File: rtl/xillylite_gpio.sv
// xillylite_gpio: memory-mapped GPIO block with per-pin direction control,
// synchronised inputs, rise/fall edge capture into a write-1-to-clear
// status register, and a level interrupt.
//
// Parameters
//   GPIO_WIDTH  : number of pins (1..32)
//   SYNC_STAGES : input synchroniser depth (2..4)
//
// Ports
//   user_clk, user_rst        : clock, synchronous active-high reset
//   user_wren, user_wstrb     : write strobe and byte enables
//   user_rden                 : read strobe
//   user_addr, user_wr_data   : byte address (bits [4:2] decoded), write data
//   user_rd_data              : registered read data, 1-cycle latency
//   user_irq                  : registered OR of STATUS
//   gpio_i / gpio_o / gpio_t  : pin input, pin output value, tristate (1 = undriven)
//
// Register map (addr[4:2]):
//   0 OUT rw, 1 DIR rw (1 = output), 2 IN ro, 3 RISE_EN rw, 4 FALL_EN rw,
//   5 STATUS w1c, 6 reserved (reads 0), 7 ID ro
module xillylite_gpio #(
  parameter int GPIO_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  user_clk,
  input  logic                  user_rst,
  input  logic                  user_wren,
  input  logic [3:0]            user_wstrb,
  input  logic                  user_rden,
  input  logic [31:0]           user_addr,
  input  logic [31:0]           user_wr_data,
  output logic [31:0]           user_rd_data,
  output logic                  user_irq,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [GPIO_WIDTH-1:0] gpio_t
);

  typedef enum logic [2:0] {
    REG_OUT  = 3'd0,
    REG_DIR  = 3'd1,
    REG_IN   = 3'd2,
    REG_RISE = 3'd3,
    REG_FALL = 3'd4,
    REG_STAT = 3'd5,
    REG_RSVD = 3'd6,
    REG_ID   = 3'd7
  } reg_e;

  // Counter must hold SYNC_STAGES+1.
  localparam int               CW        = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0]    WARM_INIT = CW'(SYNC_STAGES + 1);
  localparam logic [7:0]       ID_WIDTH  = 8'(GPIO_WIDTH);
  localparam logic [31:0]      ID_VAL    = {8'h47, 16'h0000, ID_WIDTH};

  logic [GPIO_WIDTH-1:0] out_q,     out_d;
  logic [GPIO_WIDTH-1:0] dir_q,     dir_d;
  logic [GPIO_WIDTH-1:0] rise_en_q, rise_en_d;
  logic [GPIO_WIDTH-1:0] fall_en_q, fall_en_d;
  logic [GPIO_WIDTH-1:0] status_q,  status_d;
  logic [GPIO_WIDTH-1:0] prev_q;
  logic [GPIO_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [CW-1:0]         warm_q,    warm_d;
  logic [31:0]           rd_q,      rd_d;
  logic                  irq_q;

  reg_e                  addr_sel;
  logic [31:0]           bmask;
  logic [GPIO_WIDTH-1:0] wmask;
  logic [GPIO_WIDTH-1:0] wdata;
  logic [GPIO_WIDTH-1:0] sync_now;
  logic [GPIO_WIDTH-1:0] edge_set;
  logic [GPIO_WIDTH-1:0] clr;
  logic                  unused_addr_bits;

  assign addr_sel         = reg_e'(user_addr[4:2]);
  assign unused_addr_bits = ^{user_addr[31:5], user_addr[1:0]};
  assign bmask            = {{8{user_wstrb[3]}}, {8{user_wstrb[2]}},
                             {8{user_wstrb[1]}}, {8{user_wstrb[0]}}};
  assign wmask            = bmask[GPIO_WIDTH-1:0];
  assign wdata            = user_wr_data[GPIO_WIDTH-1:0];
  assign sync_now         = sync_q[SYNC_STAGES-1];

  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    clr       = '0;
    if (user_wren) begin
      case (addr_sel)
        REG_OUT:  out_d     = (out_q     & ~wmask) | (wdata & wmask);
        REG_DIR:  dir_d     = (dir_q     & ~wmask) | (wdata & wmask);
        REG_RISE: rise_en_d = (rise_en_q & ~wmask) | (wdata & wmask);
        REG_FALL: fall_en_d = (fall_en_q & ~wmask) | (wdata & wmask);
        REG_STAT: clr       = wdata & wmask;
        default:  ;
      endcase
    end

    // Edge detection is held off until the synchroniser and delayed copy
    // have filled with real pin values, so pins static at reset stay quiet.
    if (warm_q == '0) begin
      edge_set = (sync_now & ~prev_q & rise_en_q) |
                 (~sync_now & prev_q & fall_en_q);
    end else begin
      edge_set = '0;
    end

    // OR-ing the set term last gives a new edge priority over a w1c clear.
    status_d = (status_q & ~clr) | edge_set;
    warm_d   = (warm_q == '0) ? warm_q : warm_q - CW'(1);

    rd_d = rd_q;
    if (user_rden) begin
      case (addr_sel)
        REG_OUT:  rd_d = 32'(out_q);
        REG_DIR:  rd_d = 32'(dir_q);
        REG_IN:   rd_d = 32'(sync_now);
        REG_RISE: rd_d = 32'(rise_en_q);
        REG_FALL: rd_d = 32'(fall_en_q);
        REG_STAT: rd_d = 32'(status_q);
        REG_RSVD: rd_d = '0;
        REG_ID:   rd_d = ID_VAL;
        default:  rd_d = '0;
      endcase
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      prev_q    <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      warm_q    <= WARM_INIT;
      rd_q      <= '0;
      irq_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      prev_q    <= sync_now;
      sync_q[0] <= gpio_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      warm_q    <= warm_d;
      rd_q      <= rd_d;
      irq_q     <= |status_q;
    end
  end

  assign user_rd_data = rd_q;
  assign user_irq     = irq_q;
  assign gpio_o       = out_q;
  assign gpio_t       = ~dir_q;

endmodule

// File: tb/tb_xillylite_gpio.sv
// Directed bench for xillylite_gpio: a 32-pin instance and an 8-pin
// instance share the bus; inputs change on the falling edge and outputs
// are observed on the following falling edge.
module tb_xillylite_gpio;

  logic        clk = 1'b0;
  logic        rst;
  logic        wren;
  logic [3:0]  wstrb;
  logic        rden;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata, rdata8;
  logic        irq, irq8;
  logic [31:0] gin;
  logic [31:0] gout, gtri;
  logic [7:0]  gout8, gtri8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xillylite_gpio #(.GPIO_WIDTH(32), .SYNC_STAGES(2)) dut (
    .user_clk(clk), .user_rst(rst), .user_wren(wren), .user_wstrb(wstrb),
    .user_rden(rden), .user_addr(addr), .user_wr_data(wdata),
    .user_rd_data(rdata), .user_irq(irq),
    .gpio_i(gin), .gpio_o(gout), .gpio_t(gtri)
  );

  xillylite_gpio #(.GPIO_WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .user_clk(clk), .user_rst(rst), .user_wren(wren), .user_wstrb(wstrb),
    .user_rden(rden), .user_addr(addr), .user_wr_data(wdata),
    .user_rd_data(rdata8), .user_irq(irq8),
    .gpio_i(gin[7:0]), .gpio_o(gout8), .gpio_t(gtri8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wren = 1'b1; addr = a; wdata = d; wstrb = s;
    @(negedge clk);
    wren = 1'b0; wstrb = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a);
    rden = 1'b1; addr = a;
    @(negedge clk);
    rden = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wren = 1'b0; wstrb = 4'h0; rden = 1'b0;
    addr = '0; wdata = '0; gin = '0;
    cyc(3);
    chk("rst_gpio_t", gtri, 32'hFFFF_FFFF);
    chk("rst_gpio_o", gout, 32'h0);
    chk("rst_rd_data", rdata, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    rst = 1'b0;

    // ID
    rd(32'h1C);
    chk("id32", rdata, 32'h4700_0020);
    chk("id8", rdata8, 32'h4700_0008);

    // DIR then byte-masked OUT
    wr(32'h04, 32'h0000_FFFF, 4'hF);
    wr(32'h00, 32'hA5A5_A5A5, 4'b0011);
    chk("gpio_o_masked", gout, 32'h0000_A5A5);
    chk("gpio_t_dir", gtri, 32'hFFFF_0000);
    rd(32'h00);
    chk("rd_out", rdata, 32'h0000_A5A5);
    rd(32'h04);
    chk("rd_dir", rdata, 32'h0000_FFFF);

    // Rise on pin 0: STATUS set on 3rd edge, irq on 4th
    wr(32'h0C, 32'h1, 4'hF);
    gin[0] = 1'b1;
    cyc(2);
    rd(32'h14);
    chk("status_not_early", rdata, 32'h0);
    chk("irq_not_early", {31'h0, irq}, 32'h0);
    rd(32'h14);
    chk("status_rise", rdata, 32'h1);
    chk("irq_rise", {31'h0, irq}, 32'h1);
    wr(32'h14, 32'h1, 4'hF);
    chk("irq_after_clr_1", {31'h0, irq}, 32'h1);
    cyc(1);
    chk("irq_after_clr_2", {31'h0, irq}, 32'h0);

    // Fall on pin 1, then a second fall coincident with w1c
    wr(32'h10, 32'h2, 4'hF);
    gin[1] = 1'b1;
    cyc(4);
    chk("no_rise_pin1", {31'h0, irq}, 32'h0);
    gin[1] = 1'b0;
    cyc(4);
    chk("irq_fall", {31'h0, irq}, 32'h1);
    gin[1] = 1'b1;
    cyc(4);
    gin[1] = 1'b0;
    cyc(2);
    wr(32'h14, 32'h2, 4'hF);
    rd(32'h14);
    chk("set_beats_clr", rdata, 32'h2);
    chk("irq_held", {31'h0, irq}, 32'h1);

    // Disabled pin toggles leave STATUS alone
    gin[5] = 1'b1;
    cyc(4);
    gin[5] = 1'b0;
    cyc(4);
    rd(32'h14);
    chk("disabled_pin", rdata, 32'h2);
    // w1c with byte disabled has no effect
    wr(32'h14, 32'h2, 4'b1110);
    rd(32'h14);
    chk("w1c_strobe_off", rdata, 32'h2);
    wr(32'h14, 32'h2, 4'hF);
    cyc(2);
    chk("irq_cleared", {31'h0, irq}, 32'h0);
    rd(32'h08);
    chk("in_read", rdata, 32'h0000_0001);

    // Width handling and address aliasing
    wr(32'h00, 32'hFFFF_FFFF, 4'hF);
    rd(32'h00);
    chk("out8_readback", rdata8, 32'h0000_00FF);
    chk("out32_readback", rdata, 32'hFFFF_FFFF);
    rd(32'h18);
    chk("rsvd8", rdata8, 32'h0);
    chk("rsvd32", rdata, 32'h0);
    rd(32'h100);
    chk("alias8", rdata8, 32'h0000_00FF);
    wr(32'h1C, 32'h1234_5678, 4'hF);
    rd(32'h1C);
    chk("id_ro", rdata, 32'h4700_0020);

    // Pending STATUS then reset with a read in the same cycle
    gin[0] = 1'b0;
    cyc(4);
    gin[0] = 1'b1;
    cyc(4);
    chk("irq_before_rst", {31'h0, irq}, 32'h1);
    rst = 1'b1; rden = 1'b1; addr = 32'h14;
    cyc(1);
    rden = 1'b0;
    chk("rst_read_zero", rdata, 32'h0);
    chk("rst_irq_mid", {31'h0, irq}, 32'h0);
    chk("rst_gpio_o_mid", gout, 32'h0);
    chk("rst_gpio_t_mid", gtri, 32'hFFFF_FFFF);

    // Pins high through reset, edges enabled straight after release
    gin = 32'hFFFF_FFFF;
    cyc(3);
    rst = 1'b0;
    wr(32'h0C, 32'hFFFF_FFFF, 4'hF);
    wr(32'h10, 32'hFFFF_FFFF, 4'hF);
    cyc(6);
    chk("warm_irq", {31'h0, irq}, 32'h0);
    rd(32'h14);
    chk("warm_status", rdata, 32'h0);
    rd(32'h08);
    chk("warm_in", rdata, 32'hFFFF_FFFF);
    // After warm-up, a real fall is captured
    gin[3] = 1'b0;
    cyc(4);
    rd(32'h14);
    chk("post_warm_fall", rdata, 32'h0000_0008);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
